// File: rtl/nios_reset_sequencer.sv
// Boot/reset sequencer for the MAX10 Nios II system: debounces KEY[0], stretches
// every reset to a fixed hold length and multiplexes LEDR between PIO and status.
module nios_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 64
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic [1:0] pio_led,
    output logic       nios_reset_n,
    output logic [1:0] LEDR,
    output logic [7:0] boot_count,
    output logic       busy
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] LED_HOLD    = 2'b10;
    localparam logic [1:0] LED_PRESSED = 2'b01;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_PRESSED
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_key_stable;
    logic          r_key_prev;
    logic [DW-1:0] r_deb_cnt;

    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_nios_reset_n;
    logic          r_busy;
    logic [1:0]    r_ledr;
    logic [7:0]    r_boot_count;

    logic          w_press;
    logic          w_release;

    assign w_press   = r_key_prev & ~r_key_stable;
    assign w_release = ~r_key_prev & r_key_stable;

    // Synchronizer, debouncer and edge-detect history share one reset domain.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_key_stable <= 1'b1;
            r_key_prev   <= 1'b1;
            r_deb_cnt    <= '0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_key_prev <= r_key_stable;
            if (r_sync2 == r_key_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_key_stable <= r_sync2;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    // Outputs are assigned from the next state so they change on the transition edge.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state        <= S_HOLD;
            r_hold_cnt     <= '0;
            r_nios_reset_n <= 1'b0;
            r_busy         <= 1'b1;
            r_ledr         <= LED_HOLD;
            r_boot_count   <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_press) begin
                        r_state    <= S_PRESSED;
                        r_hold_cnt <= '0;
                        r_ledr     <= LED_PRESSED;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state        <= S_RUN;
                        r_hold_cnt     <= '0;
                        r_nios_reset_n <= 1'b1;
                        r_busy         <= 1'b0;
                        r_ledr         <= pio_led;
                        r_boot_count   <= r_boot_count + 8'd1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    if (w_press) begin
                        r_state        <= S_PRESSED;
                        r_nios_reset_n <= 1'b0;
                        r_busy         <= 1'b1;
                        r_ledr         <= LED_PRESSED;
                    end else begin
                        r_ledr <= pio_led;
                    end
                end
                S_PRESSED: begin
                    if (w_release) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                        r_ledr     <= LED_HOLD;
                    end
                end
                default: begin
                    r_state        <= S_HOLD;
                    r_hold_cnt     <= '0;
                    r_nios_reset_n <= 1'b0;
                    r_busy         <= 1'b1;
                    r_ledr         <= LED_HOLD;
                end
            endcase
        end
    end

    assign nios_reset_n = r_nios_reset_n;
    assign busy         = r_busy;
    assign LEDR         = r_ledr;
    assign boot_count   = r_boot_count;

endmodule

// File: tb/tb_nios_reset_sequencer.sv
// Directed bench for nios_reset_sequencer: one instance with short debounce/hold
// lengths for timing checks, a second with minimum lengths for boot_count wrap.
module tb_nios_reset_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       key_n;
    logic [1:0] pio_led;
    logic       nrst;
    logic [1:0] ledr;
    logic [7:0] bc;
    logic       busy;

    logic       rst2;
    logic       key2;
    logic       nrst2;
    logic [1:0] ledr2;
    logic [7:0] bc2;
    logic       busy2;

    int total = 0;
    int bad   = 0;

    nios_reset_sequencer #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) u_dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst),
        .key_n         (key_n),
        .pio_led       (pio_led),
        .nios_reset_n  (nrst),
        .LEDR          (ledr),
        .boot_count    (bc),
        .busy          (busy)
    );

    nios_reset_sequencer #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1)) u_wrap (
        .MAX10_CLK1_50 (clk),
        .reset         (rst2),
        .key_n         (key2),
        .pio_led       (2'b00),
        .nios_reset_n  (nrst2),
        .LEDR          (ledr2),
        .boot_count    (bc2),
        .busy          (busy2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; pio_led = 2'b11;
        rst2 = 1'b1; key2 = 1'b1;

        // power-up: three reset edges, then release
        negs(3);
        chk("rst_nrst", {7'd0, nrst}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd1);
        chk("rst_ledr", {6'd0, ledr}, 8'h02);
        chk("rst_bc",   bc, 8'd0);
        rst = 1'b0;
        negs(7);
        chk("pu_e7_nrst", {7'd0, nrst}, 8'd0);
        chk("pu_e7_bc",   bc, 8'd0);
        negs(1);
        chk("pu_e8_nrst", {7'd0, nrst}, 8'd1);
        chk("pu_e8_busy", {7'd0, busy}, 8'd0);
        chk("pu_e8_bc",   bc, 8'd1);
        chk("pu_e8_ledr", {6'd0, ledr}, 8'h03);
        pio_led = 2'b01;
        chk("pio_delay_old", {6'd0, ledr}, 8'h03);
        negs(1);
        chk("pio_delay_new", {6'd0, ledr}, 8'h01);

        // clean press in RUN, 20 cycles low
        key_n = 1'b0;
        negs(6);
        chk("pr_e6_nrst", {7'd0, nrst}, 8'd1);
        negs(1);
        chk("pr_e7_nrst", {7'd0, nrst}, 8'd0);
        chk("pr_e7_busy", {7'd0, busy}, 8'd1);
        chk("pr_e7_ledr", {6'd0, ledr}, 8'h01);
        negs(13);
        key_n = 1'b1;
        negs(6);
        chk("rl_e6_ledr", {6'd0, ledr}, 8'h01);
        negs(1);
        chk("rl_e7_ledr", {6'd0, ledr}, 8'h02);
        chk("rl_e7_nrst", {7'd0, nrst}, 8'd0);
        negs(7);
        chk("rl_h7_nrst", {7'd0, nrst}, 8'd0);
        negs(1);
        chk("rl_h8_nrst", {7'd0, nrst}, 8'd1);
        chk("rl_h8_bc",   bc, 8'd2);

        // bounce: five 3-cycle low pulses separated by 1 cycle high
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            negs(3);
            key_n = 1'b1;
            negs(1);
        end
        negs(10);
        chk("bn_nrst", {7'd0, nrst}, 8'd1);
        chk("bn_bc",   bc, 8'd2);
        chk("bn_ledr", {6'd0, ledr}, 8'h01);

        // press landing on the hold-complete edge
        key_n = 1'b0;
        negs(7);
        chk("ph_pressed", {6'd0, ledr}, 8'h01);
        key_n = 1'b1;
        negs(7);
        chk("ph_hold", {6'd0, ledr}, 8'h02);
        negs(1);
        key_n = 1'b0;
        negs(6);
        chk("ph_e14_ledr", {6'd0, ledr}, 8'h02);
        negs(1);
        chk("ph_e15_ledr", {6'd0, ledr}, 8'h01);
        chk("ph_e15_nrst", {7'd0, nrst}, 8'd0);
        chk("ph_e15_bc",   bc, 8'd2);

        // reset while PRESSED with the key still held
        rst = 1'b1;
        negs(1);
        chk("mr_nrst", {7'd0, nrst}, 8'd0);
        chk("mr_busy", {7'd0, busy}, 8'd1);
        chk("mr_ledr", {6'd0, ledr}, 8'h02);
        chk("mr_bc",   bc, 8'd0);
        negs(1);
        rst = 1'b0;
        negs(6);
        chk("mr_e6_ledr", {6'd0, ledr}, 8'h02);
        negs(1);
        chk("mr_e7_ledr", {6'd0, ledr}, 8'h01);
        chk("mr_e7_nrst", {7'd0, nrst}, 8'd0);
        chk("mr_e7_bc",   bc, 8'd0);
        key_n = 1'b1;

        // boot_count wrap with minimum debounce and hold
        rst2 = 1'b0;
        negs(1);
        chk("wr_pu_nrst", {7'd0, nrst2}, 8'd1);
        chk("wr_pu_bc",   bc2, 8'd1);
        for (int i = 0; i < 254; i++) begin
            key2 = 1'b0;
            negs(6);
            key2 = 1'b1;
            negs(6);
        end
        chk("wr_255_bc",   bc2, 8'd255);
        chk("wr_255_nrst", {7'd0, nrst2}, 8'd1);
        key2 = 1'b0;
        negs(4);
        chk("wr_pr_ledr", {6'd0, ledr2}, 8'h01);
        key2 = 1'b1;
        negs(4);
        chk("wr_hold_bc", bc2, 8'd255);
        negs(1);
        chk("wr_256_bc",   bc2, 8'd0);
        chk("wr_256_nrst", {7'd0, nrst2}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
